// File: rtl/simd_systolic_pe.sv
// Output-stationary systolic PE with runtime SIMD split (1x16b / 2x8b / 4x4b) and column drain chain.
// Optional: define SIMD_PE_SAT_EN for saturating lane accumulation and a sticky sat_flag output.
module simd_systolic_pe #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ACC_W   = 40,
  parameter int unsigned ROW_POS = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        simd_mode,
  input  logic [DATA_W-1:0] in_a,
  input  logic              in_a_valid,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_b_valid,
  input  logic              acc_clear,
  input  logic              drain_start,
  input  logic [ACC_W-1:0]  drain_in,
  input  logic              drain_in_valid,
  output logic [DATA_W-1:0] out_a,
  output logic              out_a_valid,
  output logic [DATA_W-1:0] out_b,
  output logic              out_b_valid,
  output logic [ACC_W-1:0]  drain_out,
  output logic              drain_out_valid,
  output logic              drain_busy,
`ifdef SIMD_PE_SAT_EN
  output logic              sat_flag,
`endif
  output logic [ACC_W-1:0]  acc_out
);

  // Wide enough to hold any lane accumulator plus any lane product without overflow.
  localparam int unsigned XW   = ACC_W + 2 * DATA_W + 1;
  localparam int unsigned CntW = (ROW_POS > 0) ? $clog2(ROW_POS + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_PASS} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        mode_q, new_mode;
  logic [ACC_W-1:0]  acc_q, acc_d, post_acc, fresh_acc;
  logic [ACC_W-1:0]  dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              fire, snap;

  assign fire     = in_a_valid & in_b_valid;
  assign snap     = (state_q == S_IDLE) & drain_start;
  assign new_mode = (simd_mode == 2'd3) ? 2'd0 : simd_mode;

  // Per-mode lane datapaths: accum = acc + product, fresh = product alone (tile restart).
  for (genvar m = 0; m < 3; m++) begin : g_mode
    localparam int unsigned L  = 1 << m;
    localparam int unsigned W  = DATA_W / L;
    localparam int unsigned AW = ACC_W / L;

    logic [ACC_W-1:0]     accum, fresh;
    logic signed [W-1:0]  a_l, b_l;
    logic signed [AW-1:0] acc_l;
    logic signed [XW-1:0] prod, s_acc;
`ifdef SIMD_PE_SAT_EN
    logic                 accum_ovf, fresh_ovf;

    function automatic logic ovf(logic signed [XW-1:0] s);
      return s[XW-1:AW-1] != {(XW - AW + 1){s[XW-1]}};
    endfunction
`endif

    function automatic logic [AW-1:0] fit(logic signed [XW-1:0] s);
`ifdef SIMD_PE_SAT_EN
      if (ovf(s)) return {s[XW-1], {(AW - 1){~s[XW-1]}}};
`endif
      return s[AW-1:0];
    endfunction

    always_comb begin
      accum = '0;
      fresh = '0;
      a_l   = '0;
      b_l   = '0;
      acc_l = '0;
      prod  = '0;
      s_acc = '0;
`ifdef SIMD_PE_SAT_EN
      accum_ovf = 1'b0;
      fresh_ovf = 1'b0;
`endif
      for (int i = 0; i < int'(L); i++) begin
        a_l   = in_a[W*i +: W];
        b_l   = in_b[W*i +: W];
        acc_l = acc_q[AW*i +: AW];
        prod  = '0;
        if (fire) prod = XW'(a_l) * XW'(b_l);
        s_acc = XW'(acc_l) + prod;
        accum[AW*i +: AW] = fit(s_acc);
        fresh[AW*i +: AW] = fit(prod);
`ifdef SIMD_PE_SAT_EN
        accum_ovf = accum_ovf | ovf(s_acc);
        fresh_ovf = fresh_ovf | ovf(prod);
`endif
      end
    end
  end

`ifdef SIMD_PE_SAT_EN
  logic sat_q, sat_d, post_ovf, fresh_ovf;
`endif

  always_comb begin
    case (mode_q)
      2'd1:    post_acc = g_mode[1].accum;
      2'd2:    post_acc = g_mode[2].accum;
      default: post_acc = g_mode[0].accum;
    endcase
    case (new_mode)
      2'd1:    fresh_acc = g_mode[1].fresh;
      2'd2:    fresh_acc = g_mode[2].fresh;
      default: fresh_acc = g_mode[0].fresh;
    endcase
`ifdef SIMD_PE_SAT_EN
    case (mode_q)
      2'd1:    post_ovf = g_mode[1].accum_ovf;
      2'd2:    post_ovf = g_mode[2].accum_ovf;
      default: post_ovf = g_mode[0].accum_ovf;
    endcase
    case (new_mode)
      2'd1:    fresh_ovf = g_mode[1].fresh_ovf;
      2'd2:    fresh_ovf = g_mode[2].fresh_ovf;
      default: fresh_ovf = g_mode[0].fresh_ovf;
    endcase
    sat_d = acc_clear ? fresh_ovf : (sat_q | post_ovf);
`endif
    if (acc_clear)  acc_d = fresh_acc;
    else if (snap)  acc_d = '0;
    else            acc_d = post_acc;
  end

  // Drain FSM; dout_q doubles as the snapshot buffer while in S_OWN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (drain_start) begin
          dout_d  = post_acc;
          dv_d    = 1'b1;
          state_d = S_OWN;
        end
      end
      S_OWN: begin
        if (ROW_POS == 0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PASS;
          cnt_d   = CntW'(ROW_POS);
        end
      end
      S_PASS: begin
        if (drain_in_valid) begin
          dout_d = drain_in;
          dv_d   = 1'b1;
          cnt_d  = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= 2'd0;
      acc_q       <= '0;
      dout_q      <= '0;
      dv_q        <= 1'b0;
      out_a       <= '0;
      out_a_valid <= 1'b0;
      out_b       <= '0;
      out_b_valid <= 1'b0;
`ifdef SIMD_PE_SAT_EN
      sat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      if (acc_clear) mode_q <= new_mode;
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      dv_q        <= dv_d;
      out_a       <= in_a;
      out_a_valid <= in_a_valid;
      out_b       <= in_b;
      out_b_valid <= in_b_valid;
`ifdef SIMD_PE_SAT_EN
      sat_q       <= sat_d;
`endif
    end
  end

  assign drain_out       = dout_q;
  assign drain_out_valid = dv_q;
  assign drain_busy      = (state_q != S_IDLE);
  assign acc_out         = acc_q;
`ifdef SIMD_PE_SAT_EN
  assign sat_flag        = sat_q;
`endif

endmodule

// File: tb/tb_simd_systolic_pe.sv
// Directed bench for simd_systolic_pe (ROW_POS=2) with a lane-level arithmetic model checked every cycle.
module tb_simd_systolic_pe;

  localparam int unsigned RowPos = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  simd_mode;
  logic [15:0] in_a, in_b;
  logic        in_a_valid, in_b_valid, acc_clear, drain_start, drain_in_valid;
  logic [39:0] drain_in;
  logic [15:0] out_a, out_b;
  logic        out_a_valid, out_b_valid, drain_out_valid, drain_busy;
  logic [39:0] drain_out, acc_out;
`ifdef SIMD_PE_SAT_EN
  logic        sat_flag;
`endif

  int checks = 0;
  int errors = 0;

  simd_systolic_pe #(.DATA_W(16), .ACC_W(40), .ROW_POS(RowPos)) dut (
    .clk(clk), .reset(reset), .simd_mode(simd_mode),
    .in_a(in_a), .in_a_valid(in_a_valid), .in_b(in_b), .in_b_valid(in_b_valid),
    .acc_clear(acc_clear), .drain_start(drain_start),
    .drain_in(drain_in), .drain_in_valid(drain_in_valid),
    .out_a(out_a), .out_a_valid(out_a_valid), .out_b(out_b), .out_b_valid(out_b_valid),
    .drain_out(drain_out), .drain_out_valid(drain_out_valid), .drain_busy(drain_busy),
`ifdef SIMD_PE_SAT_EN
    .sat_flag(sat_flag),
`endif
    .acc_out(acc_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic longint sx(longint v, int w);
    longint r = v & ((longint'(1) << w) - 1);
    if (((r >> (w - 1)) & 1) != 0) r -= longint'(1) << w;
    return r;
  endfunction

  function automatic longint lane_prod(logic [15:0] a, logic [15:0] b, int m, int i);
    int w = 16 >> m;
    return sx(longint'(a) >> (w * i), w) * sx(longint'(b) >> (w * i), w);
  endfunction

  function automatic longint fitv(longint v, int aw, output bit o);
    longint hi = (longint'(1) << (aw - 1)) - 1;
    longint lo = -(longint'(1) << (aw - 1));
    o = 1'b0;
`ifdef SIMD_PE_SAT_EN
    if (v > hi) begin o = 1'b1; return hi; end
    if (v < lo) begin o = 1'b1; return lo; end
    return v;
`else
    if (v > hi || v < lo) return sx(v, aw);
    return v;
`endif
  endfunction

  function automatic logic [39:0] pack(longint l0, longint l1, longint l2, longint l3, int m);
    longint l[4];
    logic [39:0] r = '0;
    int n = 1 << m;
    int aw = 40 / n;
    l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
    for (int i = 0; i < n; i++)
      r |= 40'((l[i] & ((longint'(1) << aw) - 1)) << (aw * i));
    return r;
  endfunction

  int          m_mode, m_rem;
  longint      m_lane[4];
  bit          m_sat, m_busy, m_skip, m_dv;
  logic [39:0] m_dout;
  logic [15:0] m_oa, m_ob;
  logic        m_oav, m_obv;

  longint post[4], fresh[4];
  bit     o, po, fo, fire;
  int     nm;

  always @(posedge clk) begin
    if (reset) begin
      m_mode <= 0; m_rem <= 0; m_sat <= 0; m_busy <= 0; m_skip <= 0; m_dv <= 0;
      m_dout <= '0; m_oa <= '0; m_ob <= '0; m_oav <= 0; m_obv <= 0;
      for (int i = 0; i < 4; i++) m_lane[i] <= 0;
    end else begin
      fire = in_a_valid && in_b_valid;
      nm   = (simd_mode == 2'd3) ? 0 : int'(simd_mode);
      po   = 0;
      fo   = 0;
      for (int i = 0; i < 4; i++) begin
        post[i]  = 0;
        fresh[i] = 0;
        if (i < (1 << m_mode)) begin
          post[i] = fitv(m_lane[i] + (fire ? lane_prod(in_a, in_b, m_mode, i) : 0),
                         40 >> m_mode, o);
          po |= o;
        end
        if (i < (1 << nm)) begin
          fresh[i] = fitv(fire ? lane_prod(in_a, in_b, nm, i) : 0, 40 >> nm, o);
          fo |= o;
        end
      end
      m_oa <= in_a; m_oav <= in_a_valid; m_ob <= in_b; m_obv <= in_b_valid;
      if (acc_clear) begin
        m_mode <= nm;
        m_sat  <= fo;
        for (int i = 0; i < 4; i++) m_lane[i] <= fresh[i];
      end else begin
        m_sat <= m_sat | po;
        for (int i = 0; i < 4; i++) m_lane[i] <= (!m_busy && drain_start) ? 0 : post[i];
      end
      if (!m_busy && drain_start) begin
        m_dout <= pack(post[0], post[1], post[2], post[3], m_mode);
        m_dv   <= 1; m_busy <= 1; m_skip <= 1; m_rem <= RowPos;
      end else if (m_busy && m_skip) begin
        m_dv <= 0; m_skip <= 0;
        if (m_rem == 0) m_busy <= 0;
      end else if (m_busy && drain_in_valid) begin
        m_dout <= drain_in; m_dv <= 1; m_rem <= m_rem - 1;
        if (m_rem == 1) m_busy <= 0;
      end else begin
        m_dv <= 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("out_a", out_a, m_oa);
    chk("out_a_valid", out_a_valid, m_oav);
    chk("out_b", out_b, m_ob);
    chk("out_b_valid", out_b_valid, m_obv);
    chk("acc_out", acc_out, pack(m_lane[0], m_lane[1], m_lane[2], m_lane[3], m_mode));
    chk("drain_out_valid", drain_out_valid, m_dv);
    if (m_dv) chk("drain_out", drain_out, m_dout);
    chk("drain_busy", drain_busy, m_busy);
`ifdef SIMD_PE_SAT_EN
    chk("sat_flag", sat_flag, m_sat);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    simd_mode = 2'd0; in_a = '0; in_b = '0; in_a_valid = 0; in_b_valid = 0;
    acc_clear = 0; drain_start = 0; drain_in = '0; drain_in_valid = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    idle();
  endtask

  task automatic mac(input logic [15:0] a, input logic [15:0] b);
    in_a = a; in_b = b; in_a_valid = 1; in_b_valid = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_acc", acc_out, 0);
    chk("rst_dv", drain_out_valid, 0);
    chk("rst_busy", drain_busy, 0);
    chk("rst_out_a", out_a, 0);
    reset = 0;

    // Mode 0: 3 x (3 * -5)
    acc_clear = 1; simd_mode = 2'd0; tick();
    mac(16'd3, 16'hFFFB); tick();
    chk("m0_fwd_a", out_a, 16'd3);
    chk("m0_acc1", acc_out, 40'hFFFFFFFFF1);
    repeat (2) begin mac(16'd3, 16'hFFFB); tick(); end
    chk("m0_acc3", acc_out, 40'hFFFFFFFFD3);

    // Reserved mode 3 behaves as mode 0; clear with MAC loads the product
    acc_clear = 1; simd_mode = 2'd3; mac(16'd3, 16'hFFFB); tick();
    chk("m3_acc", acc_out, 40'hFFFFFFFFF1);

    // Mode 1 lanes: -1*4 and 2*3
    acc_clear = 1; simd_mode = 2'd1; mac(16'h02FF, 16'h0304); tick();
    chk("m1_acc", acc_out, 40'h00006FFFFC);
    chk("m1_fwd_b", out_b, 16'h0304);

    // Mode 2: 2 x 7*7 per lane, then a mode change without clear is ignored
    acc_clear = 1; simd_mode = 2'd2; tick();
    repeat (2) begin mac(16'h7777, 16'h7777); tick(); end
    chk("m2_acc98", acc_out, {4{10'd98}});
    simd_mode = 2'd0; mac(16'h7777, 16'h7777); tick();
    chk("m2_nochg", acc_out, {4{10'd147}});

    // Drain through ROW_POS=2 while accumulating 2*3 per cycle
    acc_clear = 1; simd_mode = 2'd0; mac(16'd10, 16'd10); tick();
    chk("dr_acc100", acc_out, 40'd100);
    drain_start = 1; tick();
    chk("dr_own_v", drain_out_valid, 1);
    chk("dr_own_d", drain_out, 40'd100);
    chk("dr_acc0", acc_out, 0);
    mac(16'd2, 16'd3); drain_in = 40'd55; drain_in_valid = 1; tick();
    chk("dr_drop", drain_out_valid, 0);
    mac(16'd2, 16'd3); drain_in = 40'd7; drain_in_valid = 1; tick();
    chk("dr_w7", drain_out, 40'd7);
    chk("dr_w7v", drain_out_valid, 1);
    mac(16'd2, 16'd3); tick();
    chk("dr_gap", drain_out_valid, 0);
    mac(16'd2, 16'd3); drain_in = 40'd9; drain_in_valid = 1; drain_start = 1; tick();
    chk("dr_w9", drain_out, 40'd9);
    chk("dr_idle", drain_busy, 0);
    chk("dr_ign", acc_out, 40'd24);

    // MAC on the drain_start cycle lands in the buffer; reset mid-drain
    drain_start = 1; mac(16'd5, 16'd5); tick();
    chk("ds_buf", drain_out, 40'd49);
    chk("ds_acc", acc_out, 0);
    tick();
    drain_in = 40'd1; drain_in_valid = 1; tick();
    chk("rm_w1", drain_out_valid, 1);
    reset = 1; drain_in = 40'd2; drain_in_valid = 1; tick();
    reset = 0;
    chk("rm_dv", drain_out_valid, 0);
    chk("rm_busy", drain_busy, 0);

    // Mode 2 overflow: 10 x (-8 * -8) = 640 per 10-bit lane
    acc_clear = 1; simd_mode = 2'd2; tick();
    repeat (10) begin mac(16'h8888, 16'h8888); tick(); end
`ifdef SIMD_PE_SAT_EN
    chk("sat_acc", acc_out, {4{10'd511}});
    chk("sat_set", sat_flag, 1);
    acc_clear = 1; tick();
    chk("sat_clr", sat_flag, 0);
`else
    chk("wrap_acc", acc_out, {4{10'h280}});
`endif
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/simd_systolic_pe.md
Name: simd_systolic_pe

Overview:
- Integer output-stationary systolic PE with a runtime-selectable SIMD lane split: 1x16b, 2x8b or 4x4b signed MACs.
- Adds valid-qualified operand forwarding, per-lane accumulators with tile clear, and a column drain chain that shifts results south without stalling accumulation.
- Tiled in an R x C array; row index ROW_POS sets how many upstream drain words each PE forwards.

Parameters:
DATA_W, 16, operand width; must be divisible by 4
ACC_W, 40, total accumulator width; must be divisible by 4; lane accumulator = ACC_W/L
ROW_POS, 0, number of PEs north of this one in the column (drain words to forward)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
simd_mode  in  2  lane split: 0=1 lane, 1=2 lanes, 2=4 lanes, 3=reserved (treated as 0); sampled only on acc_clear
in_a  in  DATA_W  west operand
in_a_valid  in  1  west operand valid
in_b  in  DATA_W  north operand
in_b_valid  in  1  north operand valid
acc_clear  in  1  start new tile: latch simd_mode, restart accumulators
drain_start  in  1  snapshot accumulators into drain buffer and begin drain
drain_in  in  ACC_W  drain word from north neighbour
drain_in_valid  in  1  drain_in qualifier
out_a  out  DATA_W  east operand (registered in_a)
out_a_valid  out  1  registered in_a_valid
out_b  out  DATA_W  south operand (registered in_b)
out_b_valid  out  1  registered in_b_valid
drain_out  out  ACC_W  drain word to south neighbour
drain_out_valid  out  1  drain_out qualifier
drain_busy  out  1  high while not in S_IDLE
acc_out  out  ACC_W  live accumulator (debug/observe)

Behaviour:
- Reset: all outputs 0, accumulators 0, latched mode 0, FSM S_IDLE.
- Forwarding: out_a/out_b and their valids registered every cycle, 1-cycle latency; data forwarded even when valid=0.
- MAC fires when in_a_valid && in_b_valid. Result visible on acc_out the next cycle.
- Lane L (L=1,2,4): operand width W=DATA_W/L; lane i uses bits [W*i +: W] of in_a and in_b, signed. Accumulator width AW=ACC_W/L; lane i occupies bits [AW*i +: AW].
- Per-lane update: acc_i += sext(a_i)*sext(b_i). Wraps modulo 2^AW; no carry between lanes.
- acc_clear: latch simd_mode. If the MAC fires the same cycle, each lane loads its product; otherwise all lanes load 0.
- Changing simd_mode without acc_clear has no effect.
- FSM states: S_IDLE, S_OWN, S_PASS.
- S_IDLE + drain_start:
  - Drain buffer takes the post-update accumulator value (includes a MAC firing that cycle).
  - Accumulators are cleared in the same cycle, so the next tile accumulates immediately.
  - Go to S_OWN.
- S_OWN: drain_out = buffer, drain_out_valid = 1 for exactly one cycle.
  - If ROW_POS=0, go to S_IDLE; otherwise go to S_PASS with pass counter = ROW_POS.
- S_PASS: register drain_in -> drain_out with 1-cycle latency.
  - Each cycle with drain_in_valid: drain_out_valid=1 and decrement the counter.
  - At counter 0, go to S_IDLE.
  - Cycles without drain_in_valid drive drain_out_valid=0 and hold the counter.
- drain_start outside S_IDLE is ignored; the accumulators are not snapshotted and not cleared.
- drain_start together with acc_clear: the snapshot takes priority, and the accumulators take the acc_clear rule above.
- drain_in_valid in S_IDLE or S_OWN is dropped.
- Reset mid-drain: FSM returns to S_IDLE and drain_out_valid drops the next cycle.

Optional Feature:
- Macro: SIMD_PE_SAT_EN.
- Defined: per-lane accumulation saturates to [-2^(AW-1), 2^(AW-1)-1]. Add output sat_flag (1 bit), set sticky on any lane saturation and cleared by acc_clear or reset.
- Undefined: modulo wrap, no sat_flag port.

Test Plan:
- Mode 0, acc_clear, then 3 cycles of a=3, b=-5, both valid -> acc_out = -45; out_a=3 one cycle after each input.
- Mode 1, in_a=0x02FF, in_b=0x0304 -> lane0 = -4, lane1 = 6 (acc_out = {20'd6, 20'hFFFFC}).
- Mode 2, in_a=in_b=0x7777 for 2 cycles -> each 10-bit lane = 98.
- ROW_POS=2: drain_start with acc=100, then drain_in = 7, 9 (valid, one gap cycle between them) -> drain_out_valid sequence 100, 7, 9. During the drain, MACs accumulate from 0 and drain_busy drops after 9.
- drain_start during S_PASS -> ignored, accumulators keep their value; MAC on the drain_start cycle -> buffer includes the product and the accumulator is 0 next cycle.
- SIMD_PE_SAT_EN, mode 2, a=b=-8 for 10 cycles -> lanes hold 511 and sat_flag=1. Without the macro: 640 wraps to -384.
